// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for DIGITS active-low 7-segment digits sharing one
//   segment bus. An internal prescaler sets the slot rate. Supported display
//   features are hex or clamped-BCD glyphs, leading-zero blanking, per-digit
//   blank/blink/decimal point, and a shadowed frame that only reloads at the
//   frame boundary, so a frame is never torn.
module seven_seg_scanner #(
    parameter int DIGITS     = 4,
    parameter int SCAN_BITS  = 13,
    parameter int BLINK_BITS = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  lz_suppress,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     DIGIT,
    output logic [6:0]            DISPLAY,
    output logic                  DP,
    output logic                  frame_done
);

    localparam int               IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [SCAN_BITS-1:0]  presc;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;
    logic                  pending;

    logic                  tick;
    logic                  boundary;
    logic                  capture;
    logic [IDX_W-1:0]      idx_nxt;
    logic [4*DIGITS-1:0]   frame_val;
    logic [DIGITS-1:0]     frame_dp;
    logic [3:0]            nib_p0;
    logic                  sel_dp;
    logic                  sel_blank;
    logic                  sel_blink;
    logic                  lead_zero;
    logic                  off_p0;

    // In BCD mode nibbles above 9 saturate to 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] n, input logic hex);
        return (!hex && (n > 4'd9)) ? 4'd9 : n;
    endfunction

    // Active-low segment pattern {a,b,c,d,e,f,g} for one nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Free-running prescaler and blink counter; prescaler wrap marks a slot tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            blink_cnt <= '0;
        end else begin
            presc     <= presc + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Slot sequencing, frame capture decision and glyph for the slot about to be shown.
    // When the frame reloads, the incoming value bypasses the shadow so digit 0
    // of the new frame already shows it.
    always_comb begin
        tick      = (presc == '1);
        boundary  = tick && (idx == LAST_IDX);
        capture   = boundary && (pending || load);
        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        frame_val = capture ? value : shadow_val;
        frame_dp  = capture ? dp_in : shadow_dp;

        nib_p0    = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        sel_blink = 1'b0;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_nxt) begin
                nib_p0    = frame_val[4*i +: 4];
                sel_dp    = frame_dp[i];
                sel_blank = blank_mask[i];
                sel_blink = blink_mask[i];
            end
            if ((IDX_W'(i) >= idx_nxt) && (frame_val[4*i +: 4] != 4'd0)) begin
                lead_zero = 1'b0;
            end
        end

        off_p0 = sel_blank
               || (sel_blink && blink_cnt[BLINK_BITS-1])
               || (lz_suppress && (idx_nxt != '0) && lead_zero);
    end

    // Slot index, pending load request and the frame shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= LAST_IDX;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (tick) begin
                idx <= idx_nxt;
            end
            if (capture) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b0;
            end else if (load) begin
                pending    <= 1'b1;
            end
        end
    end

    // ---- output register stage: glyph latched on each tick, held between ticks ----
    // Registered anode, segment, decimal-point and frame pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DIGIT      <= '1;
            DISPLAY    <= 7'b1111111;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                if (off_p0) begin
                    DIGIT   <= '1;
                    DISPLAY <= 7'b1111111;
                    DP      <= 1'b1;
                end else begin
                    DIGIT   <= ~(DIGITS'(1) << idx_nxt);
                    DISPLAY <= seg_code(clamp_bcd(nib_p0, hex_mode));
                    DP      <= ~sel_dp;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner (DIGITS=4 plus an 8-digit instance, SCAN_BITS=2, BLINK_BITS=6).
module tb_seven_seg_scanner;

    localparam int D = 4;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic [15:0] value       = '0;
    logic        load        = 1'b0;
    logic        hex_mode    = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  blank_mask  = '0;
    logic [3:0]  blink_mask  = '0;
    logic [3:0]  dp_in       = '0;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        DP;
    logic        frame_done;

    logic [31:0] value8 = 32'h87654321;
    logic [7:0]  zero8  = '0;
    logic        lz8    = 1'b0;
    logic [7:0]  digit8;
    logic [6:0]  display8;
    logic        dp8;
    logic        fd8;

    seven_seg_scanner #(.DIGITS(4), .SCAN_BITS(2), .BLINK_BITS(6)) u_dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .lz_suppress(lz_suppress), .blank_mask(blank_mask), .blink_mask(blink_mask),
        .dp_in(dp_in), .DIGIT(DIGIT), .DISPLAY(DISPLAY), .DP(DP), .frame_done(frame_done)
    );

    seven_seg_scanner #(.DIGITS(8), .SCAN_BITS(2), .BLINK_BITS(6)) u_dut8 (
        .clk(clk), .reset(reset), .value(value8), .load(load), .hex_mode(hex_mode),
        .lz_suppress(lz8), .blank_mask(zero8), .blink_mask(zero8),
        .dp_in(zero8), .DIGIT(digit8), .DISPLAY(display8), .DP(dp8), .frame_done(fd8)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Edges since reset release are counted; every 4th edge is a slot tick,
    // slot k shows digit (k-1) mod 4, and the blink phase is the upper half of
    // a 64-cycle period.
    int          m_cyc;
    int          m_d;
    bit          m_took;
    bit          m_pend;
    logic [15:0] m_shadow;
    logic [3:0]  m_sdp;
    logic [3:0]  exp_digit = 4'hF;
    logic [6:0]  exp_disp  = 7'h7F;
    logic        exp_dp    = 1'b1;
    logic        exp_fd    = 1'b0;

    task automatic model_glyph(input int d, input bit phase);
        bit lead;
        bit off;
        int n;
        lead = 1'b1;
        for (int j = d; j < D; j++) if (m_shadow[4*j +: 4] != 4'd0) lead = 1'b0;
        off = blank_mask[d] || (blink_mask[d] && phase) || (lz_suppress && d > 0 && lead);
        if (off) begin
            exp_digit = 4'hF;
            exp_disp  = 7'h7F;
            exp_dp    = 1'b1;
        end else begin
            n = int'(m_shadow[4*d +: 4]);
            if (!hex_mode && n > 9) n = 9;
            exp_digit    = 4'hF;
            exp_digit[d] = 1'b0;
            exp_disp     = seg_tab[n];
            exp_dp       = ~m_sdp[d];
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc     = 0;
            m_pend    = 1'b0;
            m_shadow  = '0;
            m_sdp     = '0;
            exp_digit = 4'hF;
            exp_disp  = 7'h7F;
            exp_dp    = 1'b1;
            exp_fd    = 1'b0;
        end else begin
            m_cyc++;
            exp_fd = 1'b0;
            m_took = 1'b0;
            if (m_cyc % 4 == 0) begin
                m_d = (m_cyc / 4 - 1) % D;
                if (m_d == 0) begin
                    exp_fd = 1'b1;
                    if (m_pend || load) begin
                        m_shadow = value;
                        m_sdp    = dp_in;
                        m_pend   = 1'b0;
                        m_took   = 1'b1;
                    end
                end
                model_glyph(m_d, ((m_cyc - 1) % 64) >= 32);
            end
            if (load && !m_took) m_pend = 1'b1;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_digit", 32'(DIGIT), 32'(exp_digit));
        chk("m_display", 32'(DISPLAY), 32'(exp_disp));
        chk("m_dp", 32'(DP), 32'(exp_dp));
        chk("m_frame_done", 32'(frame_done), 32'(exp_fd));
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [15:0] val;
        logic        hex;
        logic        lz;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  lit;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t tbl [8];

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL fd_timeout: no frame_done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic apply_vec(input int k, input vec_t v);
        bit         ok;
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic       e_dp;
        @(negedge clk);
        value = v.val; hex_mode = v.hex; lz_suppress = v.lz;
        blank_mask = v.blank; blink_mask = 4'h0; dp_in = v.dp; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(ok);
        if (ok) begin
            for (int s = 0; s < D; s++) begin
                e_dig = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
                if (v.lit[s]) begin
                    e_dig[s] = 1'b0;
                    e_seg    = v.segs[7*s +: 7];
                    e_dp     = ~v.dp[s];
                end
                chk($sformatf("vec%0d_digit_s%0d", k, s), 32'(DIGIT), 32'(e_dig));
                chk($sformatf("vec%0d_seg_s%0d", k, s), 32'(DISPLAY), 32'(e_seg));
                chk($sformatf("vec%0d_dp_s%0d", k, s), 32'(DP), 32'(e_dp));
                repeat (4) @(negedge clk);
            end
        end
    endtask

    // Called with reset low: release with a load pulse, first digit lit 4 cycles later.
    task automatic release_seq();
        value = 16'h1234; hex_mode = 1'b0; lz_suppress = 1'b0;
        blank_mask = '0; blink_mask = '0; dp_in = '0; load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rel_digit_before_tick", 32'(DIGIT), 32'(4'hF));
        @(negedge clk);
        chk("rel_digit_first", 32'(DIGIT), 32'(4'b1110));
        chk("rel_display_first", 32'(DISPLAY), 32'(7'b1001100));
        chk("rel_frame_done", 32'(frame_done), 32'd1);
    endtask

    initial begin
        bit         ok;
        int         cnt;
        logic [7:0] e8;
        logic [15:0] msk;

        tbl[0] = '{16'h1234, 1'b0, 1'b0, 4'h0, 4'h0, 4'b1111,
                   {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        tbl[1] = '{16'h00AF, 1'b0, 1'b0, 4'h0, 4'h0, 4'b1111,
                   {7'b0000001, 7'b0000001, 7'b0000100, 7'b0000100}};
        tbl[2] = '{16'h00AF, 1'b1, 1'b0, 4'h0, 4'h0, 4'b1111,
                   {7'b0000001, 7'b0000001, 7'b0001000, 7'b0111000}};
        tbl[3] = '{16'h0050, 1'b0, 1'b1, 4'h0, 4'h0, 4'b0011,
                   {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}};
        tbl[4] = '{16'h0000, 1'b0, 1'b1, 4'h0, 4'h0, 4'b0001,
                   {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
        tbl[5] = '{16'h1234, 1'b0, 1'b0, 4'b0100, 4'b0010, 4'b1011,
                   {7'b1001111, 7'h7F, 7'b0000110, 7'b1001100}};
        tbl[6] = '{16'h0C0E, 1'b1, 1'b1, 4'h0, 4'h0, 4'b0111,
                   {7'h7F, 7'b0110001, 7'b0000001, 7'b0110000}};
        tbl[7] = '{16'h0D0B, 1'b1, 1'b0, 4'h0, 4'b1001, 4'b1111,
                   {7'b0000001, 7'b1000010, 7'b0000001, 7'b1100000}};

        #1 reset = 1'b0;
        value = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_digit", 32'(DIGIT), 32'(4'hF));
        chk("rst_display", 32'(DISPLAY), 32'(7'h7F));
        chk("rst_dp", 32'(DP), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_digit8", 32'(digit8), 32'(8'hFF));

        release_seq();

        for (int k = 0; k < 8; k++) apply_vec(k, tbl[k]);

        // Tear test: a mid-frame reload must wait for the next frame.
        @(negedge clk);
        value = 16'h1111; hex_mode = 1'b0; lz_suppress = 1'b0;
        blank_mask = '0; blink_mask = '0; dp_in = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd(ok);
        if (ok) begin
            for (int s = 0; s < D; s++) begin
                chk($sformatf("tear_old_s%0d", s), 32'(DISPLAY), 32'(7'b1001111));
                if (s == 1) begin
                    @(negedge clk);
                    value = 16'h2222;
                    load  = 1'b1;
                    @(negedge clk);
                    load = 1'b0;
                    repeat (2) @(negedge clk);
                end else begin
                    repeat (4) @(negedge clk);
                end
            end
            chk("tear_boundary_fd", 32'(frame_done), 32'd1);
            for (int s = 0; s < D; s++) begin
                chk($sformatf("tear_new_s%0d", s), 32'(DISPLAY), 32'(7'b0010010));
                repeat (4) @(negedge clk);
            end
        end

        // Load asserted exactly on the boundary cycle, then frame period.
        wait_fd(ok);
        if (ok) begin
            repeat (15) @(negedge clk);
            value = 16'h5555;
            load  = 1'b1;
            @(negedge clk);
            load = 1'b0;
            chk("bnd_fd", 32'(frame_done), 32'd1);
            chk("bnd_digit", 32'(DIGIT), 32'(4'b1110));
            chk("bnd_display", 32'(DISPLAY), 32'(7'b0100100));
            cnt = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (frame_done) begin
                    cnt = i;
                    break;
                end
            end
            chk("fd_period", 32'(cnt), 32'd16);
        end

        // Eight-digit instance: 32-cycle frame, index wraps 7 -> 0.
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (fd8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL fd8_timeout: no frame_done on 8-digit instance at %0t", $time);
        end else begin
            for (int s = 0; s < 8; s++) begin
                e8 = ~(8'd1 << s);
                chk($sformatf("d8_digit_s%0d", s), 32'(digit8), 32'(e8));
                chk($sformatf("d8_seg_s%0d", s), 32'(display8), 32'(seg_tab[s + 1]));
                repeat (4) @(negedge clk);
            end
            chk("d8_period_fd", 32'(fd8), 32'd1);
        end

        // Blink and decimal point: model checks every cycle; DP low only in digit-1 slot.
        @(negedge clk);
        value = 16'h1234; blink_mask = 4'b0001; dp_in = 4'b0010; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (DP == 1'b0) chk("dp_slot", 32'(DIGIT), 32'(4'b1101));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: msk = 16'hFFFF;
                    1: msk = 16'h00FF;
                    2: msk = 16'h000F;
                    default: msk = 16'h0F0F;
                endcase
                value = 16'($urandom) & msk;
            end
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) begin
                hex_mode    = 1'($urandom);
                lz_suppress = 1'($urandom);
                blank_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                blink_mask  = 4'($urandom);
                dp_in       = 4'($urandom);
            end
        end
        @(negedge clk);
        load = 1'b0;

        // Reset pulsed mid-frame: outputs off at once, sequence restarts from digit 0.
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_digit", 32'(DIGIT), 32'(4'hF));
        chk("mid_rst_display", 32'(DISPLAY), 32'(7'h7F));
        chk("mid_rst_dp", 32'(DP), 32'd1);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        chk("mid_rst_digit8", 32'(digit8), 32'(8'hFF));
        repeat (2) @(negedge clk);
        release_seq();
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
